instr_fetch_unit: RTL and testbench

Instruction-fetch stage of the single-issue RISC-V core. Holds the program counter, drives the word address of the 64-entry combinational instruction memory, and captures the returned word into an IF/ID register that is presented to decode with a valid/ready handshake. Also handles control-flow redirects from execute, detects `ecall` (program termination), and flags illegal fetch targets.

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and fetch-state encoding for the instruction-fetch stage.
package instr_fetch_unit_pkg;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_HALT  = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC, imem addressing, IF/ID register with valid/ready,
// execute redirects, ecall halt and sticky illegal-target fault.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic               halted,
    output logic               fault
);
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] WIN_MASK = (32'd1 << (IMEM_AW + 2)) - 32'd1;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         halted_q, fault_q;
    logic         load;

    // Legal target: word aligned and inside the instruction-memory window.
    function automatic logic target_ok(input logic [31:0] t);
        return (t[1:0] == 2'b00) && ((t & ~WIN_MASK) == '0);
    endfunction

    assign load = (state_q == FS_RUN) && (!if_valid_q || id_ready);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        // Redirect outranks load, stall and the ecall transition; FAULT ignores it.
        if ((state_q != FS_FAULT) && redirect_valid) begin
            if_valid_d = 1'b0;
            if (target_ok(redirect_pc)) begin
                pc_d    = redirect_pc;
                state_d = FS_RUN;
            end else begin
                state_d = FS_FAULT;
            end
        end else if (load) begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = (pc_q + 32'd4) & WIN_MASK;
            if (imem_data == INSTR_ECALL) begin
                state_d = FS_HALT;
            end
        end else if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_RUN;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= INSTR_NOP;
            if_pc_q    <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= (state_d == FS_HALT);
            fault_q    <= (state_d == FS_FAULT);
        end
    end

    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences and a
// randomized run against a cycle-level reference model.
module tb_instr_fetch_unit;

    localparam int unsigned AW = 6;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EC  = 32'h0000_0073;
    localparam logic [31:0] P0  = 32'habcde337;
    localparam logic [31:0] P1  = 32'h00001397;
    localparam logic [31:0] P2  = 32'h00000417;
    localparam logic [31:0] P3  = 32'hff840413;
    localparam logic [31:0] P4  = 32'h00642023;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_ready;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic          halted;
    logic          fault;

    logic [31:0] mem [64];
    assign imem_data = mem[imem_addr];

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        eh;
        logic        ef;
        logic [5:0]  ea;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic ev,
                                logic [31:0] ei, logic [31:0] ep, logic eh, logic ef,
                                logic [5:0] ea);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.ei = ei;
        v.ep = ep; v.eh = eh; v.ef = ef; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic compare_all(input string tag, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic eh, input logic ef,
                               input logic [5:0] ea);
        chk({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, ev});
        chk({tag, ".if_instr"},  if_instr, ei);
        chk({tag, ".if_pc"},     if_pc, ep);
        chk({tag, ".halted"},    {31'd0, halted}, {31'd0, eh});
        chk({tag, ".fault"},     {31'd0, fault}, {31'd0, ef});
        chk({tag, ".imem_addr"}, {26'd0, imem_addr}, {26'd0, ea});
    endtask

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_halt, m_fault;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        if (!m_fault && rv) begin
            m_valid = 1'b0;
            if (rpc % 4 != 0 || rpc >= 32'd256) begin
                m_fault = 1'b1;
                m_halt  = 1'b0;
            end else begin
                m_pc   = rpc;
                m_halt = 1'b0;
            end
        end else if (!m_halt && !m_fault && (!m_valid || rdy)) begin
            m_instr = mem[(m_pc / 4) % 64];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 4) % 256;
            if (m_instr == EC) m_halt = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        #1;
        compare_all(tag, 1'b0, NOP, 32'h0, 1'b0, 1'b0, 6'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic apply(input vec_t v, input string tag);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        id_ready       = v.rdy;
        @(posedge clk);
        @(negedge clk);
        compare_all(tag, v.ev, v.ei, v.ep, v.eh, v.ef, v.ea);
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0] = P0; mem[1] = P1; mem[2] = P2; mem[3] = P3;
        mem[4] = P4; mem[7] = EC;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? EC : $urandom;
    endtask

    initial begin
        logic        rv, rdy;
        logic [31:0] rpc;

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        load_program();

        // Stream, back-pressure, halt, redirects, redirect-vs-ecall, fault.
        vt.push_back(mk(0, 32'h0,  1, 1, P0,  32'd0,  0, 0, 6'd1));
        vt.push_back(mk(0, 32'h0,  1, 1, P1,  32'd4,  0, 0, 6'd2));
        vt.push_back(mk(0, 32'h0,  1, 1, P2,  32'd8,  0, 0, 6'd3));
        vt.push_back(mk(0, 32'h0,  0, 1, P2,  32'd8,  0, 0, 6'd3));
        vt.push_back(mk(0, 32'h0,  0, 1, P2,  32'd8,  0, 0, 6'd3));
        vt.push_back(mk(0, 32'h0,  0, 1, P2,  32'd8,  0, 0, 6'd3));
        vt.push_back(mk(0, 32'h0,  1, 1, P3,  32'd12, 0, 0, 6'd4));
        vt.push_back(mk(0, 32'h0,  1, 1, P4,  32'd16, 0, 0, 6'd5));
        vt.push_back(mk(0, 32'h0,  1, 1, NOP, 32'd20, 0, 0, 6'd6));
        vt.push_back(mk(0, 32'h0,  1, 1, NOP, 32'd24, 0, 0, 6'd7));
        vt.push_back(mk(0, 32'h0,  1, 1, EC,  32'd28, 1, 0, 6'd8));
        vt.push_back(mk(0, 32'h0,  0, 1, EC,  32'd28, 1, 0, 6'd8));
        vt.push_back(mk(0, 32'h0,  1, 0, EC,  32'd28, 1, 0, 6'd8));
        vt.push_back(mk(0, 32'h0,  1, 0, EC,  32'd28, 1, 0, 6'd8));
        vt.push_back(mk(1, 32'h10, 1, 0, EC,  32'd28, 0, 0, 6'd4));
        vt.push_back(mk(0, 32'h0,  1, 1, P4,  32'd16, 0, 0, 6'd5));
        vt.push_back(mk(0, 32'h0,  0, 1, P4,  32'd16, 0, 0, 6'd5));
        vt.push_back(mk(1, 32'h10, 0, 0, P4,  32'd16, 0, 0, 6'd4));
        vt.push_back(mk(0, 32'h0,  1, 1, P4,  32'd16, 0, 0, 6'd5));
        vt.push_back(mk(0, 32'h0,  1, 1, NOP, 32'd20, 0, 0, 6'd6));
        vt.push_back(mk(0, 32'h0,  1, 1, NOP, 32'd24, 0, 0, 6'd7));
        vt.push_back(mk(1, 32'h4,  1, 0, NOP, 32'd24, 0, 0, 6'd1));
        vt.push_back(mk(0, 32'h0,  1, 1, P1,  32'd4,  0, 0, 6'd2));
        vt.push_back(mk(1, 32'h6,  1, 0, P1,  32'd4,  0, 1, 6'd2));
        vt.push_back(mk(1, 32'h10, 1, 0, P1,  32'd4,  0, 1, 6'd2));
        vt.push_back(mk(0, 32'h0,  1, 0, P1,  32'd4,  0, 1, 6'd2));

        do_reset("reset0");
        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("row%0d", i));

        // Reset asserted while faulted, then out-of-window target.
        do_reset("reset_in_fault");
        apply(mk(0, 32'h0,   1, 1, P0,  32'd0,    0, 0, 6'd1),  "oob0");
        apply(mk(1, 32'h100, 1, 0, P0,  32'd0,    0, 1, 6'd1),  "oob1");

        // Sequential wrap from the last word of the window.
        do_reset("reset_wrap");
        apply(mk(1, 32'hfc,  1, 0, NOP, 32'd0,    0, 0, 6'd63), "wrap0");
        apply(mk(0, 32'h0,   1, 1, NOP, 32'hfc,   0, 0, 6'd0),  "wrap1");
        apply(mk(0, 32'h0,   1, 1, P0,  32'd0,    0, 0, 6'd1),  "wrap2");

        randomize_mem();
        do_reset("rnd_reset");
        for (int n = 0; n < 3000; n++) begin
            if (m_fault && $urandom_range(0, 3) == 0) begin
                randomize_mem();
                do_reset("rnd_reset");
            end
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       rpc = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       rpc = {$urandom_range(1, 255), 8'd0} | {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                default: rpc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            redirect_valid = rv;
            redirect_pc    = rpc;
            id_ready       = rdy;
            model_step(rv, rpc, rdy);
            @(posedge clk);
            @(negedge clk);
            compare_all($sformatf("rnd%0d", n), m_valid, m_instr, m_ipc, m_halt, m_fault,
                        m_pc[7:2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
